// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite engine write path: register map,
// scheduler FSM states and the address legality check.
package sprite_pkg;

    localparam int V_ACTIVE = 768;

    typedef enum logic [5:0] {
        SPR0_POS  = 6'h04,
        SPR0_BMP0 = 6'h06, SPR0_BMP1 = 6'h08, SPR0_BMP2 = 6'h0A,
        SPR0_BMP3 = 6'h0C, SPR0_BMP4 = 6'h0E, SPR0_BMP5 = 6'h10,
        SPR0_BMP6 = 6'h12, SPR0_BMP7 = 6'h14, SPR0_BMP8 = 6'h16,
        SPR1_POS  = 6'h1A,
        SPR1_BMP0 = 6'h1C, SPR1_BMP1 = 6'h1E, SPR1_BMP2 = 6'h20,
        SPR1_BMP3 = 6'h22, SPR1_BMP4 = 6'h24, SPR1_BMP5 = 6'h26,
        SPR1_BMP6 = 6'h28, SPR1_BMP7 = 6'h2A, SPR1_BMP8 = 6'h2C
    } spr_reg_e;

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, GAP} state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_req_t;

    // 0x18 sits between the two sprite banks and is not a register.
    function automatic logic is_legal_addr(input logic [5:0] addr);
        return !addr[0] &&
               ((addr >= SPR0_POS && addr <= SPR0_BMP8) ||
                (addr >= SPR1_POS && addr <= SPR1_BMP8));
    endfunction

endpackage

// File: rtl/sprite_wr_fifo.sv
// Synchronous FIFO for pending engine writes; push and pop may coincide,
// including when full, in which case the pop frees the slot for the push.
module sprite_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 22,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LVL_W'(1);
            else if (do_pop && !do_push) level <= level - LVL_W'(1);
        end
    end

    // NOTE: storage has no reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sprite_write_sched.sv
// Round-robin write scheduler in front of the sprite engine register port;
// drains queued writes only inside the vblank / stream-off window, under a per-frame budget.
module sprite_write_sched
    import sprite_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BUDGET = 16,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stream_en,
    input  logic             vblank,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_addr,
    input  logic [15:0]      req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_addr,
    input  logic [15:0]      req1_data,
    output logic             wr_en,
    output logic [5:0]       wr_addr,
    output logic [15:0]      wr_data,
    output logic [LVL_W-1:0] fifo_level,
    output logic             busy,
    output logic             addr_err
);
    localparam int CNT_W = (BUDGET > 0) ? $clog2(BUDGET + 1) : 1;
    localparam logic [CNT_W-1:0] BUDGET_C = CNT_W'(BUDGET);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    wr_req_t          head;
    wr_req_t          sel;
    logic [CNT_W-1:0] cnt;
    logic             full, empty, rr, vblank_q;
    logic             win, can_issue, pop, space, acc, legal, push, both;

    assign win       = !stream_en || vblank;
    assign can_issue = win && !empty && (BUDGET == 0 || cnt < BUDGET_C);
    assign pop       = (state == WAIT || state == GAP) && can_issue && !flush;
    assign space     = (!full || pop) && !flush;

    // When both requesters are valid exactly one ready is high, chosen by rr.
    assign both       = req0_valid && req1_valid;
    assign req0_ready = space && !(both && rr);
    assign req1_ready = space && !(both && !rr);
    assign acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign sel        = (req1_valid && req1_ready) ? '{addr: req1_addr, data: req1_data}
                                                   : '{addr: req0_addr, data: req0_data};
    assign legal      = is_legal_addr(sel.addr);
    assign push       = acc && legal;
    assign busy       = (state != IDLE) || (fifo_level != '0);

    sprite_wr_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wr_req_t)),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (sel),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr       <= 1'b0;
            addr_err <= 1'b0;
        end else if (flush) begin
            rr       <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (both && acc)    rr       <= !rr;
            if (acc && !legal)  addr_err <= 1'b1;
        end
    end

    // GAP may pop directly so back-to-back writes sustain one strobe per two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cnt      <= '0;
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
            wr_en    <= 1'b0;
            if (pop) begin
                wr_en   <= 1'b1;
                wr_addr <= head.addr;
                wr_data <= head.data;
            end

            if (!stream_en)                         cnt <= '0;
            else if (vblank && !vblank_q)           cnt <= '0;
            else if (state == ISSUE && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (!empty) state <= WAIT;
                    WAIT:    if (pop)    state <= ISSUE;
                    ISSUE:   state <= GAP;
                    GAP:     state <= pop ? ISSUE : (!empty ? WAIT : IDLE);
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
